// File: rtl/ysyx_24110015_axi_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_24110015_axi_rr_arbiter
// Brief   : Single-outstanding AXI4 round-robin arbiter (IFU read, LSU r/w)
//           with a per-transaction watchdog that answers SLVERR on timeout.
// Revision: 1.0 - initial release
// ============================================================================
module ysyx_24110015_axi_rr_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    // IFU read address / data
    input  logic                  ifu_arvalid,
    output logic                  ifu_arready,
    input  logic [ADDR_W-1:0]     ifu_araddr,
    input  logic [ID_W-1:0]       ifu_arid,
    input  logic [7:0]            ifu_arlen,
    input  logic [2:0]            ifu_arsize,
    input  logic [1:0]            ifu_arburst,
    output logic                  ifu_rvalid,
    input  logic                  ifu_rready,
    output logic [DATA_W-1:0]     ifu_rdata,
    output logic [1:0]            ifu_rresp,
    output logic                  ifu_rlast,
    output logic [ID_W-1:0]       ifu_rid,
    // LSU read address / data
    input  logic                  lsu_arvalid,
    output logic                  lsu_arready,
    input  logic [ADDR_W-1:0]     lsu_araddr,
    input  logic [ID_W-1:0]       lsu_arid,
    input  logic [7:0]            lsu_arlen,
    input  logic [2:0]            lsu_arsize,
    input  logic [1:0]            lsu_arburst,
    output logic                  lsu_rvalid,
    input  logic                  lsu_rready,
    output logic [DATA_W-1:0]     lsu_rdata,
    output logic [1:0]            lsu_rresp,
    output logic                  lsu_rlast,
    output logic [ID_W-1:0]       lsu_rid,
    // LSU write address / data / response
    input  logic                  lsu_awvalid,
    output logic                  lsu_awready,
    input  logic [ADDR_W-1:0]     lsu_awaddr,
    input  logic [ID_W-1:0]       lsu_awid,
    input  logic [7:0]            lsu_awlen,
    input  logic [2:0]            lsu_awsize,
    input  logic [1:0]            lsu_awburst,
    input  logic                  lsu_wvalid,
    output logic                  lsu_wready,
    input  logic [DATA_W-1:0]     lsu_wdata,
    input  logic [DATA_W/8-1:0]   lsu_wstrb,
    input  logic                  lsu_wlast,
    output logic                  lsu_bvalid,
    input  logic                  lsu_bready,
    output logic [1:0]            lsu_bresp,
    output logic [ID_W-1:0]       lsu_bid,
    // Downstream slave
    output logic                  s_arvalid,
    input  logic                  s_arready,
    output logic [ADDR_W-1:0]     s_araddr,
    output logic [ID_W-1:0]       s_arid,
    output logic [7:0]            s_arlen,
    output logic [2:0]            s_arsize,
    output logic [1:0]            s_arburst,
    input  logic                  s_rvalid,
    output logic                  s_rready,
    input  logic [DATA_W-1:0]     s_rdata,
    input  logic [1:0]            s_rresp,
    input  logic                  s_rlast,
    input  logic [ID_W-1:0]       s_rid,
    output logic                  s_awvalid,
    input  logic                  s_awready,
    output logic [ADDR_W-1:0]     s_awaddr,
    output logic [ID_W-1:0]       s_awid,
    output logic [7:0]            s_awlen,
    output logic [2:0]            s_awsize,
    output logic [1:0]            s_awburst,
    output logic                  s_wvalid,
    input  logic                  s_wready,
    output logic [DATA_W-1:0]     s_wdata,
    output logic [DATA_W/8-1:0]   s_wstrb,
    output logic                  s_wlast,
    input  logic                  s_bvalid,
    output logic                  s_bready,
    input  logic [1:0]            s_bresp,
    input  logic [ID_W-1:0]       s_bid,
    output logic                  timeout_err
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_AR    = 3'd1;
    localparam logic [2:0] c_R     = 3'd2;
    localparam logic [2:0] c_AW    = 3'd3;
    localparam logic [2:0] c_W     = 3'd4;
    localparam logic [2:0] c_B     = 3'd5;
    localparam logic [2:0] c_R_ERR = 3'd6;
    localparam logic [2:0] c_B_ERR = 3'd7;
    localparam logic [1:0] c_SLVERR = 2'b10;

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic              r_gnt_lsu;
    logic              r_last_lsu;
    logic              r_timeout_err;
    logic [ADDR_W-1:0] r_addr;
    logic [ID_W-1:0]   r_id;
    logic [7:0]        r_len;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;

    logic              w_pick_lsu;
    logic              w_gnt_ifu;
    logic              w_gnt_lsu;
    logic              w_rready_g;
    logic              w_busy;
    logic              w_hs;
    logic              w_wd_hit;
    logic              w_expire;
    logic [DATA_W-1:0] w_rdata;
    logic [1:0]        w_rresp;
    logic              w_rlast;
    logic [ID_W-1:0]   w_rid;

    // The master not granted last wins a tie; r_last_lsu resets high so IFU goes first.
    assign w_pick_lsu = (lsu_awvalid | lsu_arvalid) & (~ifu_arvalid | ~r_last_lsu);
    assign w_gnt_lsu  = w_pick_lsu;
    assign w_gnt_ifu  = ifu_arvalid & ~w_pick_lsu;
    assign w_rready_g = r_gnt_lsu ? lsu_rready : ifu_rready;

    assign w_busy = (r_state == c_AR) || (r_state == c_R) || (r_state == c_AW) ||
                    (r_state == c_W)  || (r_state == c_B);

    assign w_hs = ((r_state == c_AR) & s_arready) |
                  ((r_state == c_R)  & s_rvalid & w_rready_g) |
                  ((r_state == c_AW) & s_awready) |
                  ((r_state == c_W)  & lsu_wvalid & s_wready) |
                  ((r_state == c_B)  & s_bvalid & lsu_bready);

    // A handshake in the expiry cycle wins over the abort.
    assign w_expire = w_wd_hit & ~w_hs;

    generate
        if (TIMEOUT != 0) begin : g_wdog
            localparam int c_WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
            localparam logic [c_WD_W-1:0] c_WD_MAX = c_WD_W'(TIMEOUT - 1);
            logic [c_WD_W-1:0] r_wdog;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_wdog <= '0;
                end else if (!w_busy || w_hs || w_wd_hit) begin
                    r_wdog <= '0;
                end else begin
                    r_wdog <= r_wdog + c_WD_W'(1);
                end
            end

            assign w_wd_hit = w_busy && (r_wdog == c_WD_MAX);
        end else begin : g_no_wdog
            assign w_wd_hit = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_gnt_ifu)                      w_next = c_AR;
                else if (w_gnt_lsu && lsu_awvalid)  w_next = c_AW;
                else if (w_gnt_lsu)                 w_next = c_AR;
            end
            c_AR: begin
                if (w_expire)       w_next = c_R_ERR;
                else if (s_arready) w_next = c_R;
            end
            c_R: begin
                if (w_expire)                              w_next = c_R_ERR;
                else if (s_rvalid && w_rready_g && s_rlast) w_next = c_IDLE;
            end
            c_AW: begin
                if (w_expire)       w_next = c_B_ERR;
                else if (s_awready) w_next = c_W;
            end
            c_W: begin
                if (w_expire)                                w_next = c_B_ERR;
                else if (lsu_wvalid && s_wready && lsu_wlast) w_next = c_B;
            end
            c_B: begin
                if (w_expire)                    w_next = c_B_ERR;
                else if (s_bvalid && lsu_bready) w_next = c_IDLE;
            end
            c_R_ERR: if (w_rready_g) w_next = c_IDLE;
            c_B_ERR: if (lsu_bready) w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gnt_lsu     <= 1'b0;
            r_last_lsu    <= 1'b1;
            r_timeout_err <= 1'b0;
            r_addr        <= '0;
            r_id          <= '0;
            r_len         <= '0;
            r_size        <= '0;
            r_burst       <= '0;
        end else begin
            r_timeout_err <= w_expire;
            if (r_state == c_IDLE && (w_gnt_ifu || w_gnt_lsu)) begin
                r_gnt_lsu <= w_gnt_lsu;
                if (w_gnt_ifu) begin
                    r_addr  <= ifu_araddr;
                    r_id    <= ifu_arid;
                    r_len   <= ifu_arlen;
                    r_size  <= ifu_arsize;
                    r_burst <= ifu_arburst;
                end else if (lsu_awvalid) begin
                    r_addr  <= lsu_awaddr;
                    r_id    <= lsu_awid;
                    r_len   <= lsu_awlen;
                    r_size  <= lsu_awsize;
                    r_burst <= lsu_awburst;
                end else begin
                    r_addr  <= lsu_araddr;
                    r_id    <= lsu_arid;
                    r_len   <= lsu_arlen;
                    r_size  <= lsu_arsize;
                    r_burst <= lsu_arburst;
                end
            end
            if ((r_state == c_R && s_rvalid && w_rready_g && s_rlast) ||
                (r_state == c_R_ERR && w_rready_g)) begin
                r_last_lsu <= r_gnt_lsu;
            end
            if ((r_state == c_B && s_bvalid && lsu_bready) ||
                (r_state == c_B_ERR && lsu_bready)) begin
                r_last_lsu <= 1'b1;
            end
        end
    end

    always_comb begin
        ifu_arready = 1'b0;
        lsu_arready = 1'b0;
        lsu_awready = 1'b0;
        ifu_rvalid  = 1'b0;
        lsu_rvalid  = 1'b0;
        lsu_bvalid  = 1'b0;
        lsu_bresp   = 2'b00;
        lsu_bid     = '0;
        w_rdata     = '0;
        w_rresp     = 2'b00;
        w_rlast     = 1'b0;
        w_rid       = '0;

        s_arvalid = (r_state == c_AR);
        s_araddr  = r_addr;
        s_arid    = r_id;
        s_arlen   = r_len;
        s_arsize  = r_size;
        s_arburst = r_burst;
        s_awvalid = (r_state == c_AW);
        s_awaddr  = r_addr;
        s_awid    = r_id;
        s_awlen   = r_len;
        s_awsize  = r_size;
        s_awburst = r_burst;
        s_wvalid  = (r_state == c_W) & lsu_wvalid;
        s_wdata   = lsu_wdata;
        s_wstrb   = lsu_wstrb;
        s_wlast   = lsu_wlast;
        lsu_wready = (r_state == c_W) & s_wready;
        s_rready  = (r_state == c_R) & w_rready_g;
        s_bready  = (r_state == c_B) & lsu_bready;

        case (r_state)
            c_IDLE: begin
                ifu_arready = w_gnt_ifu;
                lsu_awready = w_gnt_lsu & lsu_awvalid;
                lsu_arready = w_gnt_lsu & ~lsu_awvalid;
            end
            c_R: begin
                ifu_rvalid = s_rvalid & ~r_gnt_lsu;
                lsu_rvalid = s_rvalid & r_gnt_lsu;
                w_rdata    = s_rdata;
                w_rresp    = s_rresp;
                w_rlast    = s_rlast;
                w_rid      = s_rid;
            end
            c_R_ERR: begin
                ifu_rvalid = ~r_gnt_lsu;
                lsu_rvalid = r_gnt_lsu;
                w_rresp    = c_SLVERR;
                w_rlast    = 1'b1;
                w_rid      = r_id;
            end
            c_B: begin
                lsu_bvalid = s_bvalid;
                lsu_bresp  = s_bresp;
                lsu_bid    = s_bid;
            end
            c_B_ERR: begin
                lsu_bvalid = 1'b1;
                lsu_bresp  = c_SLVERR;
                lsu_bid    = r_id;
            end
            default: ;
        endcase

        ifu_rdata   = w_rdata;
        ifu_rresp   = w_rresp;
        ifu_rlast   = w_rlast;
        ifu_rid     = w_rid;
        lsu_rdata   = w_rdata;
        lsu_rresp   = w_rresp;
        lsu_rlast   = w_rlast;
        lsu_rid     = w_rid;
        timeout_err = r_timeout_err;
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24110015_axi_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_ysyx_24110015_axi_rr_arbiter
// Brief   : Directed self-checking bench for the AXI round-robin arbiter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ysyx_24110015_axi_rr_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready, ifu_rlast;
    logic [31:0] ifu_araddr, ifu_rdata;
    logic [3:0]  ifu_arid, ifu_rid;
    logic [7:0]  ifu_arlen;
    logic [2:0]  ifu_arsize;
    logic [1:0]  ifu_arburst, ifu_rresp;
    logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready, lsu_rlast;
    logic [31:0] lsu_araddr, lsu_rdata;
    logic [3:0]  lsu_arid, lsu_rid;
    logic [7:0]  lsu_arlen;
    logic [2:0]  lsu_arsize;
    logic [1:0]  lsu_arburst, lsu_rresp;
    logic        lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready, lsu_wlast;
    logic        lsu_bvalid, lsu_bready;
    logic [31:0] lsu_awaddr, lsu_wdata;
    logic [3:0]  lsu_awid, lsu_bid, lsu_wstrb;
    logic [7:0]  lsu_awlen;
    logic [2:0]  lsu_awsize;
    logic [1:0]  lsu_awburst, lsu_bresp;
    logic        s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
    logic [31:0] s_araddr, s_rdata;
    logic [3:0]  s_arid, s_rid;
    logic [7:0]  s_arlen;
    logic [2:0]  s_arsize;
    logic [1:0]  s_arburst, s_rresp;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
    logic [31:0] s_awaddr, s_wdata;
    logic [3:0]  s_awid, s_bid, s_wstrb;
    logic [7:0]  s_awlen;
    logic [2:0]  s_awsize;
    logic [1:0]  s_awburst, s_bresp;
    logic        timeout_err;

    int n_checks = 0;
    int n_errors = 0;
    int beat;

    always #5 clk = ~clk;

    ysyx_24110015_axi_rr_arbiter #(
        .ADDR_W(32), .DATA_W(32), .ID_W(4), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst),
        .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr),
        .ifu_arid(ifu_arid), .ifu_arlen(ifu_arlen), .ifu_arsize(ifu_arsize),
        .ifu_arburst(ifu_arburst), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
        .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rlast(ifu_rlast), .ifu_rid(ifu_rid),
        .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready), .lsu_araddr(lsu_araddr),
        .lsu_arid(lsu_arid), .lsu_arlen(lsu_arlen), .lsu_arsize(lsu_arsize),
        .lsu_arburst(lsu_arburst), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
        .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rlast(lsu_rlast), .lsu_rid(lsu_rid),
        .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready), .lsu_awaddr(lsu_awaddr),
        .lsu_awid(lsu_awid), .lsu_awlen(lsu_awlen), .lsu_awsize(lsu_awsize),
        .lsu_awburst(lsu_awburst), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
        .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wlast(lsu_wlast),
        .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready), .lsu_bresp(lsu_bresp), .lsu_bid(lsu_bid),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
        .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_rlast(s_rlast), .s_rid(s_rid),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid),
        .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_wlast(s_wlast), .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_bid(s_bid), .timeout_err(timeout_err)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in an IDLE cycle with requests already applied; completes one single-beat read.
    task automatic rd_txn(input bit exp_lsu, input logic [31:0] exp_addr, input logic [31:0] data);
        check_eq("gnt_ifu", ifu_arready, !exp_lsu);
        check_eq("gnt_lsu", lsu_arready, exp_lsu);
        check_eq("idle_no_s_ar", s_arvalid, 0);
        tick();
        check_eq("s_arvalid", s_arvalid, 1);
        check_eq("s_araddr", s_araddr, exp_addr);
        s_arready = 1'b1;
        tick();
        s_arready  = 1'b0;
        s_rvalid   = 1'b1;
        s_rdata    = data;
        s_rlast    = 1'b1;
        s_rresp    = 2'b00;
        ifu_rready = 1'b1;
        lsu_rready = 1'b1;
        #1;
        check_eq("ifu_rvalid", ifu_rvalid, !exp_lsu);
        check_eq("lsu_rvalid", lsu_rvalid, exp_lsu);
        check_eq("rdata", exp_lsu ? lsu_rdata : ifu_rdata, data);
        tick();
        s_rvalid   = 1'b0;
        s_rlast    = 1'b0;
        ifu_rready = 1'b0;
        lsu_rready = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        {ifu_arvalid, ifu_rready, lsu_arvalid, lsu_rready, lsu_awvalid, lsu_wvalid, lsu_wlast, lsu_bready} = '0;
        {ifu_araddr, ifu_arid, ifu_arlen, ifu_arsize, ifu_arburst} = '0;
        {lsu_araddr, lsu_arid, lsu_arlen, lsu_arsize, lsu_arburst} = '0;
        {lsu_awaddr, lsu_awid, lsu_awlen, lsu_awsize, lsu_awburst, lsu_wdata, lsu_wstrb} = '0;
        {s_arready, s_rvalid, s_rdata, s_rresp, s_rlast, s_rid} = '0;
        {s_awready, s_wready, s_bvalid, s_bresp, s_bid} = '0;
        #3;
        check_eq("rst_s_arvalid", s_arvalid, 0);
        check_eq("rst_s_awvalid", s_awvalid, 0);
        check_eq("rst_lsu_wready", lsu_wready, 0);
        check_eq("rst_timeout_err", timeout_err, 0);
        check_eq("rst_s_araddr", s_araddr, 0);
        tick();
        rst = 1'b1;

        // Tie held across three transactions: IFU, LSU, IFU
        tick();
        ifu_arvalid = 1'b1; ifu_araddr = 32'h1000_0000;
        lsu_arvalid = 1'b1; lsu_araddr = 32'h2000_0000;
        #1;
        rd_txn(1'b0, 32'h1000_0000, 32'h1111_1111);
        rd_txn(1'b1, 32'h2000_0000, 32'h2222_2222);
        rd_txn(1'b0, 32'h1000_0000, 32'h3333_3333);
        ifu_arvalid = 1'b0; lsu_arvalid = 1'b0;

        // IFU single read
        tick();
        ifu_arvalid = 1'b1; ifu_araddr = 32'h3000_0000; ifu_arlen = 8'd0; ifu_arid = 4'd3;
        #1;
        rd_txn(1'b0, 32'h3000_0000, 32'hDEAD_BEEF);
        ifu_arvalid = 1'b0;
        #1;
        check_eq("t1_idle_s_arvalid", s_arvalid, 0);
        check_eq("t1_idle_s_rready", s_rready, 0);

        // LSU burst write, IFU waiting
        tick();
        lsu_awvalid = 1'b1; lsu_awaddr = 32'h8000_0010; lsu_awlen = 8'd3; lsu_awid = 4'd5;
        #1;
        check_eq("t3_awready", lsu_awready, 1);
        check_eq("t3_ifu_arready", ifu_arready, 0);
        tick();
        lsu_awvalid = 1'b0;
        ifu_arvalid = 1'b1; ifu_araddr = 32'h3000_0100;
        #1;
        check_eq("t3_s_awvalid", s_awvalid, 1);
        check_eq("t3_s_awaddr", s_awaddr, 32'h8000_0010);
        check_eq("t3_s_awlen", s_awlen, 3);
        check_eq("t3_s_awid", s_awid, 5);
        s_awready = 1'b1;
        tick();
        s_awready = 1'b0;
        beat = 0;
        for (int c = 0; c < 20 && beat < 4; c++) begin
            lsu_wvalid = 1'b1;
            lsu_wdata  = 32'hA0 + beat;
            lsu_wstrb  = 4'hF;
            lsu_wlast  = (beat == 3);
            s_wready   = (c % 2 == 1);
            #1;
            check_eq("t3_s_wvalid", s_wvalid, 1);
            check_eq("t3_s_wdata", s_wdata, 32'hA0 + beat);
            check_eq("t3_s_wlast", s_wlast, beat == 3);
            check_eq("t3_wready", lsu_wready, c % 2 == 1);
            check_eq("t3_ifu_wait", ifu_arready, 0);
            if (s_wready) beat++;
            tick();
        end
        lsu_wvalid = 1'b0; lsu_wlast = 1'b0; s_wready = 1'b0;
        check_eq("t3_w_beats", beat, 4);
        s_bvalid = 1'b1; s_bresp = 2'b00; s_bid = 4'd5;
        #1;
        check_eq("t3_wready_off", lsu_wready, 0);
        check_eq("t3_bvalid", lsu_bvalid, 1);
        check_eq("t3_bid", lsu_bid, 5);
        check_eq("t3_s_bready_low", s_bready, 0);
        check_eq("t3_ifu_wait_b", ifu_arready, 0);
        tick();
        lsu_bready = 1'b1;
        #1;
        check_eq("t3_s_bready", s_bready, 1);
        tick();
        s_bvalid = 1'b0; lsu_bready = 1'b0;
        #1;
        rd_txn(1'b0, 32'h3000_0100, 32'h4444_4444);
        ifu_arvalid = 1'b0;

        // LSU 8-beat read burst with rready stalls; IFU waits, then tie must go to IFU
        tick();
        lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_0100; lsu_arlen = 8'd7;
        #1;
        check_eq("t4_lsu_arready", lsu_arready, 1);
        tick();
        lsu_arvalid = 1'b0; ifu_arvalid = 1'b1; ifu_araddr = 32'h3000_0200;
        #1;
        check_eq("t4_s_arlen", s_arlen, 7);
        s_arready = 1'b1;
        tick();
        s_arready = 1'b0;
        ifu_rready = 1'b1;
        beat = 0;
        for (int c = 0; c < 40 && beat < 8; c++) begin
            s_rvalid   = 1'b1;
            s_rdata    = 32'h100 + beat;
            s_rlast    = (beat == 7);
            lsu_rready = (c % 3 != 1);
            #1;
            check_eq("t4_lsu_rvalid", lsu_rvalid, 1);
            check_eq("t4_rdata", lsu_rdata, 32'h100 + beat);
            check_eq("t4_ifu_rvalid", ifu_rvalid, 0);
            check_eq("t4_ifu_wait", ifu_arready, 0);
            check_eq("t4_s_rready", s_rready, c % 3 != 1);
            if (lsu_rready) beat++;
            tick();
        end
        s_rvalid = 1'b0; s_rlast = 1'b0; lsu_rready = 1'b0; ifu_rready = 1'b0;
        check_eq("t4_r_beats", beat, 8);
        lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_0200;
        #1;
        rd_txn(1'b0, 32'h3000_0200, 32'h5555_AAAA);
        ifu_arvalid = 1'b0; lsu_arvalid = 1'b0;

        // Watchdog: slave never accepts AR
        tick();
        ifu_arvalid = 1'b1; ifu_araddr = 32'h3000_0300; ifu_arid = 4'd9;
        #1;
        check_eq("t5_arready", ifu_arready, 1);
        tick();
        ifu_arvalid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            check_eq("t5_ar_held", s_arvalid, 1);
            check_eq("t5_no_err_yet", timeout_err, 0);
            tick();
        end
        #1;
        check_eq("t5_timeout_err", timeout_err, 1);
        check_eq("t5_s_arvalid_drop", s_arvalid, 0);
        check_eq("t5_rvalid", ifu_rvalid, 1);
        check_eq("t5_rresp", ifu_rresp, 2'b10);
        check_eq("t5_rlast", ifu_rlast, 1);
        check_eq("t5_rdata", ifu_rdata, 0);
        check_eq("t5_rid", ifu_rid, 9);
        tick();
        check_eq("t5_pulse_end", timeout_err, 0);
        check_eq("t5_rvalid_held", ifu_rvalid, 1);
        ifu_rready = 1'b1;
        tick();
        ifu_rready = 1'b0;
        #1;
        check_eq("t5_idle_rvalid", ifu_rvalid, 0);

        // Asynchronous reset during write beat 2
        tick();
        lsu_awvalid = 1'b1; lsu_awaddr = 32'h8000_0400; lsu_awlen = 8'd3;
        #1;
        check_eq("t6_awready", lsu_awready, 1);
        tick();
        lsu_awvalid = 1'b0; s_awready = 1'b1;
        tick();
        s_awready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            lsu_wvalid = 1'b1; lsu_wdata = 32'hB0 + i; s_wready = 1'b1;
            tick();
        end
        lsu_wdata = 32'hB2; s_wready = 1'b0;
        #1;
        check_eq("t6_pre_wvalid", s_wvalid, 1);
        #1;
        rst = 1'b0;
        #1;
        check_eq("t6_rst_wvalid", s_wvalid, 0);
        check_eq("t6_rst_wready", lsu_wready, 0);
        check_eq("t6_rst_awvalid", s_awvalid, 0);
        check_eq("t6_rst_bvalid", lsu_bvalid, 0);
        lsu_wvalid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        ifu_arvalid = 1'b1; lsu_arvalid = 1'b1;
        #1;
        check_eq("t6_tie_ifu", ifu_arready, 1);
        check_eq("t6_tie_lsu", lsu_arready, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
